riscv_test_monitor: RTL
=======================

Name: riscv_test_monitor

Overview:
- Completion monitor for riscv-tests runs (rv32ui-p-*) on Core; sits directly downstream of the core's data-memory write port and fetch PC.
- Snoops stores to the tohost word and decodes PASS/FAIL/test number.
- Adds a cycle-budget timeout and a PC-stall hang detector.
- Presents sticky, registered verdict flags that the simulation top uses to end the run and report results.

Parameters:
- TOHOST_ADDR, 32'h0000_1000, byte address of the tohost word (word-aligned).
- MAX_CYCLES, 5000, enabled-cycle budget before TIMEOUT.
- HANG_CYCLES, 64, consecutive enabled cycles with unchanged pc that declare HANG.
- CYC_W, 32, width of the cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- en  in  1  monitor enable; counting and detection occur only while 1.
- mem_we  in  1  data-memory write strobe from the core.
- mem_addr  in  32  data-memory byte address.
- mem_wdata  in  32  store data.
- mem_wstrb  in  4  byte enables of the store.
- pc  in  32  current fetch PC of the core.
- done  out  1  sticky; any terminal state reached.
- pass  out  1  sticky; tohost == 1 observed.
- fail  out  1  sticky; failing tohost value observed.
- timeout  out  1  sticky; MAX_CYCLES exhausted.
- hang  out  1  sticky; pc stalled HANG_CYCLES.
- test_num  out  31  failing test number (tohost[31:1]); 0 otherwise.
- cycles  out  CYC_W  enabled cycles elapsed; freezes on done.

Behaviour:
- States: RUN, PASS, FAIL, TIMEOUT, HANG. All except RUN are terminal; the monitor leaves them only through reset.
- Reset (rst=0, asynchronous):
  - state=RUN.
  - All flags 0, test_num=0, cycles=0, stall counter=0.
  - pc_prev=32'h0.
- tohost hit is defined as: en & mem_we & (mem_addr[31:2]==TOHOST_ADDR[31:2]) & (mem_wstrb==4'hF).
  - Partial-strobe writes to the address are ignored.
- Hit decode (RUN only):
  - wdata==0: ignored.
  - wdata==1: PASS.
  - Any other value: FAIL, with test_num <= wdata[31:1].
- Latency: the verdict flag and done assert on the clock edge that samples the hit and are visible the following cycle. One-cycle registered latency, no combinational path from inputs to outputs.
- Cycle counter:
  - Increments by 1 on each RUN cycle with en=1.
  - On reaching MAX_CYCLES, moves to TIMEOUT; cycles holds MAX_CYCLES.
  - Saturates at all-ones and never wraps.
- Hang detector:
  - In RUN with en=1, if pc==pc_prev the stall count increments; otherwise it clears to 0.
  - pc_prev <= pc every enabled cycle.
  - Stall count reaching HANG_CYCLES moves to HANG.
  - The stall count saturates.
- en=0: counters, pc_prev and state hold; stores are ignored.
- Simultaneous events in one cycle, priority order: tohost hit > TIMEOUT > HANG. Exactly one verdict flag is ever set.
- Terminal states:
  - Further stores, including a later tohost=1 after FAIL, are ignored.
  - cycles is frozen.
  - done = pass|fail|timeout|hang.
- Reset asserted mid-run: every output clears asynchronously, and the monitor restarts in RUN once rst returns high.

Decomposition:
- Shared package (test_pkg):
  - Monitor state encoding (RUN=0, PASS=1, FAIL=2, TIMEOUT=3, HANG=4; 3 bits).
  - TOHOST default address constant.
  - PASS code constant 32'h1.
- One natural sub-module: sat_counter (parameterised width, enable, sync clear, saturating, async active-low reset).
  - Instanced twice: cycle counter and stall counter.

Test Plan:
- PASS: after reset, en=1, store wdata=32'h1, wstrb=4'hF to 32'h1000 at cycle 120 -> pass=1, done=1 at cycle 121; cycles=120; fail/timeout/hang=0.
- FAIL decode: store wdata=32'h0000_000B to 32'h1000 -> fail=1, test_num=5; a subsequent store of 32'h1 leaves pass=0.
- Filtering: byte store (wstrb=4'h1) to 32'h1000, word store to 32'h1004, and word store of 32'h0 to 32'h1000 -> no state change; a following valid 32'h1 store -> pass=1.
- Timeout vs hit: MAX_CYCLES=50, no stores, pc toggling -> timeout=1 with cycles=50. Repeat with the tohost=1 hit on the exact cycle the budget expires -> pass=1, timeout=0.
- Hang and en gating: pc held at 32'h0000_0040 for 64 enabled cycles -> hang=1. Same stimulus with en=0 for 20 of those cycles -> hang is delayed by 20 cycles and cycles excludes them.
- Async reset mid-run: rst=0 between clock edges at cycle 30 -> all outputs 0 immediately. After release, a tohost=1 store -> pass=1 with cycles counted from 0.

Source files
------------

// File: rtl/riscv_test_monitor_pkg.sv
// test_pkg: shared monitor state encoding and tohost constants.
package test_pkg;
  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_PASS    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_HANG    = 3'd4
  } state_e;
  localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_1000;
  localparam logic [31:0] PASS_CODE       = 32'h0000_0001;
endpackage

// File: rtl/riscv_test_monitor_sat_counter.sv
// sat_counter: saturating up-counter with sync clear and async active-low reset.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_en       : increment (ignored once all-ones)
//   i_clr      : synchronous clear, wins over i_en
//   o_q        : count value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_q <= '0;
    else if (i_clr) r_q <= '0;
    else if (i_en && r_q != '1) r_q <= r_q + 1'b1;
  assign o_q = r_q;
endmodule

// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: riscv-tests completion monitor (tohost snoop, timeout, pc-hang).
//   clk, rst                      : clock, asynchronous active-low reset
//   en                            : monitor enable
//   mem_we/addr/wdata/wstrb       : core data-memory write port
//   pc                            : core fetch pc
//   done/pass/fail/timeout/hang   : sticky verdict flags decoded from the state register
//   test_num                      : failing test number, 0 otherwise
//   cycles                        : enabled RUN cycles elapsed, frozen once done
module riscv_test_monitor
  import test_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEF,
  parameter int          MAX_CYCLES  = 5000,
  parameter int          HANG_CYCLES = 64,
  parameter int          CYC_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mem_we,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  input  logic [31:0]      pc,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic             hang,
  output logic [30:0]      test_num,
  output logic [CYC_W-1:0] cycles
);
  localparam int ST_W = $clog2(HANG_CYCLES + 1);
  state_e           r_state, w_state_nxt;
  logic [31:0]      r_pc_prev;
  logic [30:0]      r_test_num;
  logic [CYC_W-1:0] w_cycles;
  logic [ST_W-1:0]  w_stall;
  logic             w_act, w_same, w_hit, w_tmo, w_hng;
  assign w_act  = (r_state == ST_RUN) & en;
  assign w_same = pc == r_pc_prev;
  // a tohost store of zero carries no verdict, so it is not treated as a hit
  assign w_hit  = mem_we & (mem_addr[31:2] == TOHOST_ADDR[31:2]) & (mem_wstrb == 4'hF) & (mem_wdata != '0);
  // both limits fire on the edge that takes the counter onto the limit
  assign w_tmo  = w_cycles >= CYC_W'(MAX_CYCLES - 1);
  assign w_hng  = w_same & (w_stall >= ST_W'(HANG_CYCLES - 1));
  sat_counter #(.W(CYC_W)) u_cyc (
    .clk(clk), .rst_n(rst), .i_en(w_act), .i_clr(1'b0), .o_q(w_cycles)
  );
  sat_counter #(.W(ST_W)) u_stall (
    .clk(clk), .rst_n(rst), .i_en(w_act & w_same), .i_clr(w_act & ~w_same), .o_q(w_stall)
  );
  always_comb begin
    w_state_nxt = r_state;
    if (w_act)
      w_state_nxt = w_hit ? (mem_wdata == PASS_CODE ? ST_PASS : ST_FAIL) :
                    w_tmo ? ST_TIMEOUT :
                    w_hng ? ST_HANG : ST_RUN;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state    <= ST_RUN;
      r_pc_prev  <= '0;
      r_test_num <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (en) r_pc_prev <= pc;
      if (w_act && w_hit && mem_wdata != PASS_CODE) r_test_num <= mem_wdata[31:1];
    end
  assign pass     = r_state == ST_PASS;
  assign fail     = r_state == ST_FAIL;
  assign timeout  = r_state == ST_TIMEOUT;
  assign hang     = r_state == ST_HANG;
  assign done     = r_state != ST_RUN;
  assign test_num = r_test_num;
  assign cycles   = w_cycles;
endmodule
